// File: rtl/int_mac_pipe.sv
// Pipelined integer dot-product MAC: lane products, lane-sum reduction, grouped
// accumulation with wrap/saturate overflow policy, and a held result register.
module int_mac_pipe #(
   parameter int ELEM_W = 4,
   parameter int LANES  = 64,
   parameter int ACC_W  = 24,
   parameter int SAT    = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [(LANES+2)*ELEM_W-1:0] a_vec,
   input  logic [(LANES+2)*ELEM_W-1:0] b_vec,
   input  logic                        in_first,
   input  logic                        in_last,
   input  logic                        signed_mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_W-1:0]            out_sum,
   output logic [2*ELEM_W-1:0]         out_scale_a,
   output logic [2*ELEM_W-1:0]         out_scale_b,
   output logic                        out_ovf
);

   localparam int PW    = 2 * ELEM_W;
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int SUM_W = PW + CNT_W;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. The whole pipeline freezes while a result waits unconsumed.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~rst & ~stall;

   // Stage 1: per-lane products, operands extended to full product width
   logic [LANES*PW-1:0] prod_c;
   logic [PW-1:0]       ae, be;
   always_comb begin
      prod_c = '0;
      ae     = '0;
      be     = '0;
      for (int i = 0; i < LANES; i++) begin
         ae = {{ELEM_W{signed_mode & a_vec[(i+2)*ELEM_W+ELEM_W-1]}}, a_vec[(i+2)*ELEM_W +: ELEM_W]};
         be = {{ELEM_W{signed_mode & b_vec[(i+2)*ELEM_W+ELEM_W-1]}}, b_vec[(i+2)*ELEM_W +: ELEM_W]};
         prod_c[i*PW +: PW] = ae * be;
      end
   end

   logic                s1_valid, s1_first, s1_last, s1_mode;
   logic [LANES*PW-1:0] s1_prod;
   logic [PW-1:0]       s1_scale_a, s1_scale_b;

   // Stage 2: full-precision reduction of all lanes
   logic [SUM_W-1:0] sum_c;
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_c = sum_c + {{CNT_W{s1_mode & s1_prod[i*PW+PW-1]}}, s1_prod[i*PW +: PW]};
      end
   end

   logic             s2_valid, s2_first, s2_last, s2_mode;
   logic [SUM_W-1:0] s2_sum;
   logic [PW-1:0]    s2_scale_a, s2_scale_b;

   // Stage 3: accumulate on one extra bit so overflow is visible per beat
   logic [ACC_W-1:0] acc_q, acc_base, acc_c, sat_c;
   logic             ovf_q, ovf_c, beat_ovf;
   logic [ACC_W:0]   ext_acc, ext_sum, total;
   always_comb begin
      acc_base = s2_first ? '0 : acc_q;
      ext_acc  = {s2_mode & acc_base[ACC_W-1], acc_base};
      ext_sum  = {{(ACC_W+1-SUM_W){s2_mode & s2_sum[SUM_W-1]}}, s2_sum};
      total    = ext_acc + ext_sum;
      beat_ovf = s2_mode ? (total[ACC_W] ^ total[ACC_W-1]) : total[ACC_W];
      sat_c    = s2_mode ? (total[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                         : {ACC_W{1'b1}};
      acc_c    = (SAT != 0 && beat_ovf) ? sat_c : total[ACC_W-1:0];
      ovf_c    = (s2_first ? 1'b0 : ovf_q) | beat_ovf;
   end

   logic             s3_valid, s3_ovf;
   logic [ACC_W-1:0] s3_sum;
   logic [PW-1:0]    s3_scale_a, s3_scale_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_first    <= 1'b0;
         s1_last     <= 1'b0;
         s1_mode     <= 1'b0;
         s1_prod     <= '0;
         s1_scale_a  <= '0;
         s1_scale_b  <= '0;
         s2_valid    <= 1'b0;
         s2_first    <= 1'b0;
         s2_last     <= 1'b0;
         s2_mode     <= 1'b0;
         s2_sum      <= '0;
         s2_scale_a  <= '0;
         s2_scale_b  <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         s3_valid    <= 1'b0;
         s3_ovf      <= 1'b0;
         s3_sum      <= '0;
         s3_scale_a  <= '0;
         s3_scale_b  <= '0;
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_scale_a <= '0;
         out_scale_b <= '0;
         out_ovf     <= 1'b0;
      end else if (!stall) begin
         s1_valid   <= in_valid;
         s1_first   <= in_first;
         s1_last    <= in_last;
         s1_mode    <= signed_mode;
         s1_prod    <= prod_c;
         s1_scale_a <= a_vec[PW-1:0];
         s1_scale_b <= b_vec[PW-1:0];

         s2_valid   <= s1_valid;
         s2_first   <= s1_first;
         s2_last    <= s1_last;
         s2_mode    <= s1_mode;
         s2_sum     <= sum_c;
         s2_scale_a <= s1_scale_a;
         s2_scale_b <= s1_scale_b;

         // A finished group hands its total to s3 and leaves a clean accumulator
         if (s2_valid) begin
            if (s2_last) begin
               acc_q <= '0;
               ovf_q <= 1'b0;
            end else begin
               acc_q <= acc_c;
               ovf_q <= ovf_c;
            end
         end
         s3_valid <= s2_valid & s2_last;
         if (s2_valid && s2_last) begin
            s3_sum     <= acc_c;
            s3_ovf     <= ovf_c;
            s3_scale_a <= s2_scale_a;
            s3_scale_b <= s2_scale_b;
         end

         out_valid <= s3_valid;
         if (s3_valid) begin
            out_sum     <= s3_sum;
            out_ovf     <= s3_ovf;
            out_scale_a <= s3_scale_a;
            out_scale_b <= s3_scale_b;
         end
      end
   end

endmodule

// File: tb/tb_int_mac_pipe.sv
// Directed bench for int_mac_pipe: one 24-bit wrapping instance plus 16-bit
// saturating and wrapping instances sharing the same stimulus.
module tb_int_mac_pipe;

   localparam int ELEM_W = 4;
   localparam int LANES  = 64;
   localparam int VW     = (LANES + 2) * ELEM_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [VW-1:0] a_vec = '0;
   logic [VW-1:0] b_vec = '0;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic          signed_mode = 1'b0;
   logic          out_ready = 1'b1;

   logic          in_ready, out_valid, out_ovf;
   logic [23:0]   out_sum;
   logic [7:0]    out_scale_a, out_scale_b;

   logic          s_in_ready, s_out_valid, s_out_ovf;
   logic [15:0]   s_out_sum;
   logic [7:0]    s_scale_a, s_scale_b;
   logic          w_in_ready, w_out_valid, w_out_ovf;
   logic [15:0]   w_out_sum;
   logic [7:0]    w_scale_a, w_scale_b;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];

   always #5 clk = ~clk;

   int_mac_pipe #(.ELEM_W(ELEM_W), .LANES(LANES), .ACC_W(24), .SAT(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_vec(a_vec), .b_vec(b_vec), .in_first(in_first), .in_last(in_last),
      .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_scale_a(out_scale_a), .out_scale_b(out_scale_b),
      .out_ovf(out_ovf));

   int_mac_pipe #(.ELEM_W(ELEM_W), .LANES(LANES), .ACC_W(16), .SAT(1)) dut_s16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .a_vec(a_vec), .b_vec(b_vec), .in_first(in_first), .in_last(in_last),
      .signed_mode(signed_mode), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sum(s_out_sum), .out_scale_a(s_scale_a), .out_scale_b(s_scale_b),
      .out_ovf(s_out_ovf));

   int_mac_pipe #(.ELEM_W(ELEM_W), .LANES(LANES), .ACC_W(16), .SAT(0)) dut_w16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .a_vec(a_vec), .b_vec(b_vec), .in_first(in_first), .in_last(in_last),
      .signed_mode(signed_mode), .out_valid(w_out_valid), .out_ready(out_ready),
      .out_sum(w_out_sum), .out_scale_a(w_scale_a), .out_scale_b(w_scale_b),
      .out_ovf(w_out_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] mk(input logic [3:0] op, input logic [7:0] sc);
      logic [VW-1:0] v;
      v = '0;
      v[7:0] = sc;
      for (int i = 2; i < LANES + 2; i++) v[i*ELEM_W +: ELEM_W] = op;
      return v;
   endfunction

   // Drives one beat for exactly one cycle; expects it to be accepted.
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [7:0] sa,
                       input logic [7:0] sb, input logic f, input logic l, input logic m);
      a_vec = mk(a, sa);
      b_vec = mk(b, sb);
      in_first = f;
      in_last = l;
      signed_mode = m;
      in_valid = 1'b1;
      chk("in_ready_at_send", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Single-beat group a=k, b=1; waits (bounded) for acceptance.
   task automatic send_hold(input int k);
      int n;
      a_vec = mk(k[3:0], 8'h00);
      b_vec = mk(4'd1, 8'h00);
      in_first = 1'b1;
      in_last = 1'b1;
      signed_mode = 1'b0;
      in_valid = 1'b1;
      exp_q.push_back(24'(64 * k));
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("send_hold_accept_bound", (n < 20), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts edges until out_valid is seen; gives up after 20.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int got;
      int cnt;
      logic accept;
      logic [23:0] seen;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_scale_a", out_scale_a, 0);
      chk("rst_scale_b", out_scale_b, 0);
      chk("rst_out_ovf", out_ovf, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Unsigned 15*15 single-beat group, latency 3
      send(4'hF, 4'hF, 8'h00, 8'h00, 1, 1, 0);
      wait_out(lat);
      chk("latency", lat, 3);
      chk("u15_sum", out_sum, 14400);
      chk("u15_ovf", out_ovf, 0);

      // Next beat starts a new group even with first low
      send(4'h1, 4'h1, 8'h00, 8'h00, 0, 1, 0);
      wait_out(lat);
      chk("new_group_no_first", out_sum, 64);

      // Four back-to-back beats, no 14-bit masking
      send(4'hF, 4'hF, 8'h00, 8'h00, 1, 0, 0);
      send(4'hF, 4'hF, 8'h00, 8'h00, 0, 0, 0);
      send(4'hF, 4'hF, 8'h00, 8'h00, 0, 0, 0);
      send(4'hF, 4'hF, 8'h00, 8'h00, 0, 1, 0);
      wait_out(lat);
      chk("u4_latency", lat, 3);
      chk("u4_sum", out_sum, 57600);
      chk("u4_s16_sum", s_out_sum, 57600);
      chk("u4_s16_ovf", s_out_ovf, 0);

      // Signed extremes
      send(4'h8, 4'h8, 8'h00, 8'h00, 1, 1, 1);
      wait_out(lat);
      chk("s_m8m8_sum", out_sum, 4096);
      send(4'h8, 4'h7, 8'h00, 8'h00, 1, 1, 1);
      wait_out(lat);
      chk("s_m8p7_sum", out_sum, 24'hFFF200);
      chk("s_m8p7_ovf", out_ovf, 0);

      // Five beats of 14400 overflow a 16-bit accumulator
      send(4'hF, 4'hF, 8'h00, 8'h00, 1, 0, 0);
      repeat (3) send(4'hF, 4'hF, 8'h00, 8'h00, 0, 0, 0);
      send(4'hF, 4'hF, 8'h00, 8'h00, 0, 1, 0);
      wait_out(lat);
      chk("ovf24_sum", out_sum, 72000);
      chk("ovf24_flag", out_ovf, 0);
      chk("sat16_sum", s_out_sum, 65535);
      chk("sat16_ovf", s_out_ovf, 1);
      chk("wrap16_sum", w_out_sum, 6464);
      chk("wrap16_ovf", w_out_ovf, 1);

      // Scale slots pass through, operands zero; sticky flag cleared
      send(4'h0, 4'h0, 8'h21, 8'h43, 1, 1, 0);
      wait_out(lat);
      chk("scale_sum", out_sum, 0);
      chk("scale_a", out_scale_a, 8'h21);
      chk("scale_b", out_scale_b, 8'h43);
      chk("wrap16_ovf_cleared", w_out_ovf, 0);
      @(posedge clk); #1;

      // Backpressure: four beats fill the pipe, a fifth must wait
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send_hold(k);
      a_vec = mk(4'd5, 8'h00);
      b_vec = mk(4'd1, 8'h00);
      in_first = 1'b1;
      in_last = 1'b1;
      signed_mode = 1'b0;
      in_valid = 1'b1;
      exp_q.push_back(24'd320);
      for (int c = 0; c < 5; c++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_sum", out_sum, 64);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         if (out_valid) begin
            seen = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hDEAD;
            chk("bp_order_sum", out_sum, seen);
            got++;
         end
         accept = in_valid & in_ready;
         @(posedge clk); #1;
         if (accept) in_valid = 1'b0;
      end
      chk("bp_result_count", got, 5);
      chk("bp_queue_empty", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_duplicate", out_valid, 0);

      // Reset in the middle of a group
      send(4'h1, 4'h1, 8'h00, 8'h00, 1, 0, 0);
      send(4'h1, 4'h1, 8'h00, 8'h00, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_release_in_ready", in_ready, 1);
      send(4'h1, 4'h1, 8'h00, 8'h00, 1, 1, 0);
      cnt = 0;
      seen = '0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) begin
            cnt++;
            seen = out_sum;
         end
         @(posedge clk); #1;
      end
      chk("midrst_result_count", cnt, 1);
      chk("midrst_sum", seen, 64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
